// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the column decoder, synchronises and debounces the rows,
// rejects ghost/multi-key scans and reports one key code with a one-cycle strobe per press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [1:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } state_t;

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             sample_edge;
    logic             scan_end;

    logic             col_none;
    logic             col_one;
    logic             col_multi;
    logic [1:0]       col_row;

    logic             acc_one;
    logic             acc_bad;
    logic [3:0]       acc_code;

    logic             scan_one;
    logic [3:0]       scan_code;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cand;
    logic [3:0]       cand_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] rel_cnt;
    logic [CNT_W-1:0] rel_cnt_next;
    logic             accept;
    logic             release_done;

    // Idle rows read as all-ones, so the synchroniser resets to "no key".
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign sample_edge = (div_cnt == DIV_LAST);
    assign scan_end    = sample_edge && (col_sel == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            col_sel <= 2'd0;
        end else if (sample_edge) begin
            div_cnt <= '0;
            col_sel <= col_sel + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        col_none = (row_sync == 4'b1111);
        col_one  = 1'b0;
        col_row  = 2'd0;
        case (row_sync)
            4'b1110: begin col_one = 1'b1; col_row = 2'd0; end
            4'b1101: begin col_one = 1'b1; col_row = 2'd1; end
            4'b1011: begin col_one = 1'b1; col_row = 2'd2; end
            4'b0111: begin col_one = 1'b1; col_row = 2'd3; end
            default: ;
        endcase
    end

    assign col_multi = !col_none && !col_one;

    // A scan is clean only if exactly one column reported exactly one row.
    assign scan_one  = !acc_bad && !col_multi && (acc_one != col_one);
    assign scan_code = acc_one ? acc_code : {col_row, col_sel};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_one  <= 1'b0;
            acc_bad  <= 1'b0;
            acc_code <= 4'd0;
        end else if (scan_end) begin
            acc_one  <= 1'b0;
            acc_bad  <= 1'b0;
            acc_code <= 4'd0;
        end else if (sample_edge) begin
            acc_bad <= acc_bad | col_multi | (acc_one & col_one);
            acc_one <= acc_one | col_one;
            if (col_one) begin
                acc_code <= {col_row, col_sel};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cand    <= 4'd0;
            cnt     <= '0;
            rel_cnt <= '0;
        end else begin
            state   <= state_next;
            cand    <= cand_next;
            cnt     <= cnt_next;
            rel_cnt <= rel_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cand_next    = cand;
        cnt_next     = cnt;
        rel_cnt_next = rel_cnt;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (scan_one) begin
                        cand_next  = scan_code;
                        cnt_next   = CNT_ONE;
                        state_next = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (scan_one && (scan_code == cand)) begin
                        if (cnt == CNT_LAST) begin
                            state_next   = PRESSED;
                            cnt_next     = '0;
                            rel_cnt_next = '0;
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end else if (scan_one) begin
                        cand_next = scan_code;
                        cnt_next  = CNT_ONE;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                PRESSED: begin
                    if (scan_one && (scan_code == key_code)) begin
                        rel_cnt_next = '0;
                    end else if (rel_cnt == CNT_LAST) begin
                        state_next   = IDLE;
                        rel_cnt_next = '0;
                    end else begin
                        rel_cnt_next = rel_cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        accept       = (state == DEBOUNCE) && (state_next == PRESSED);
        release_done = (state == PRESSED) && (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= cand;
                key_held <= 1'b1;
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a scan-level reference model driven by the same keypad matrix
// is compared every cycle, plus scenario checks on pulse counts, codes and latencies.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 3;
    localparam int SCAN     = 4 * SCAN_DIV;
    localparam int LAT      = (DS + 1) * 4 * SCAN_DIV + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [1:0] col_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys;

    int total;
    int passed;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col_sel  (col_sel),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key in the selected column pulls its row low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~keys[4 * r + int'(col_sel)];
        end
    end

    typedef struct {
        int         div;
        int         col;
        logic [3:0] meta;
        logic [3:0] sync;
        int         ones;
        bit         bad;
        int         code;
        int         phase;
        int         cand;
        int         cnt;
        int         rel;
        bit         valid;
        bit         held;
        int         kcode;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t cur, logic [15:0] k, logic r);
        model_t n;
        int     zeros;
        int     hit;
        int     ones;
        int     code;
        bit     bad;
        bit     res_one;
        n = cur;
        if (r) begin
            n.div = 0;   n.col = 0;   n.meta = 4'hF; n.sync = 4'hF;
            n.ones = 0;  n.bad = 0;   n.code = 0;    n.phase = 0;
            n.cand = 0;  n.cnt = 0;   n.rel = 0;     n.valid = 0;
            n.held = 0;  n.kcode = 0;
            return n;
        end
        n.valid = 0;
        for (int i = 0; i < 4; i++) n.meta[i] = ~k[4 * i + cur.col];
        n.sync = cur.meta;
        if (cur.div != SCAN_DIV - 1) begin
            n.div = cur.div + 1;
            return n;
        end
        n.div = 0;
        n.col = (cur.col + 1) % 4;
        zeros = 0;
        hit   = 0;
        for (int i = 0; i < 4; i++) begin
            if (cur.sync[i] == 1'b0) begin
                zeros++;
                hit = i;
            end
        end
        ones = cur.ones + ((zeros == 1) ? 1 : 0);
        bad  = cur.bad || (zeros > 1);
        code = (zeros == 1) ? 4 * hit + cur.col : cur.code;
        if (cur.col != 3) begin
            n.ones = ones;
            n.bad  = bad;
            n.code = code;
            return n;
        end
        n.ones  = 0;
        n.bad   = 0;
        n.code  = 0;
        res_one = (ones == 1) && !bad;
        case (cur.phase)
            0: if (res_one) begin
                n.phase = 1; n.cand = code; n.cnt = 1;
            end
            1: if (res_one && code == cur.cand) begin
                if (cur.cnt + 1 == DS) begin
                    n.phase = 2; n.kcode = code; n.valid = 1; n.held = 1; n.rel = 0;
                end else begin
                    n.cnt = cur.cnt + 1;
                end
            end else if (res_one) begin
                n.cand = code; n.cnt = 1;
            end else begin
                n.phase = 0; n.cnt = 0;
            end
            default: if (res_one && code == cur.kcode) begin
                n.rel = 0;
            end else if (cur.rel + 1 == DS) begin
                n.phase = 0; n.held = 0; n.rel = 0;
            end else begin
                n.rel = cur.rel + 1;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, keys, rst);

    function automatic logic [7:0] expv();
        return {2'(m.col), 4'(m.kcode), m.valid, m.held};
    endfunction

    task automatic test_reset();
        rst  = 1'b1;
        keys = 16'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({col_sel, key_code, key_valid, key_held} !== 8'h00)
                $display("FAIL reset_outputs cycle %0d: got %b expected %b", i,
                         {col_sel, key_code, key_valid, key_held}, 8'h00);
            else passed++;
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        int pulses = 0;
        for (int i = 1; i <= 10 * SCAN; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) pulses++;
            total++;
            if (col_sel !== 2'((i / SCAN_DIV) % 4))
                $display("FAIL idle_col_step cycle %0d: got %0d expected %0d", i, col_sel,
                         (i / SCAN_DIV) % 4);
            else passed++;
            total++;
            if ({col_sel, key_code, key_valid, key_held} !== expv())
                $display("FAIL idle_model cycle %0d: got %b expected %b", i,
                         {col_sel, key_code, key_valid, key_held}, expv());
            else passed++;
        end
        total++;
        if (pulses !== 0) $display("FAIL idle_no_valid: got %0d pulses expected 0", pulses);
        else passed++;
    endtask

    task automatic test_press();
        int pulses = 0;
        int code   = -1;
        int held_lost = 0;
        int pre = $urandom_range(0, SCAN - 1);
        for (int i = 0; i < pre; i++) @(negedge clk);
        keys[6] = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                pulses++;
                code = int'(key_code);
            end
            total++;
            if ({col_sel, key_code, key_valid, key_held} !== expv())
                $display("FAIL press_model cycle %0d: got %b expected %b", i,
                         {col_sel, key_code, key_valid, key_held}, expv());
            else passed++;
        end
        total++;
        if (pulses !== 1) $display("FAIL press_pulse_count: got %0d expected 1", pulses);
        else passed++;
        total++;
        if (code !== 6) $display("FAIL press_code: got %0d expected 6", code);
        else passed++;
        pulses = 0;
        for (int i = 1; i <= 10 * SCAN; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) pulses++;
            if (key_held !== 1'b1) held_lost++;
            total++;
            if ({col_sel, key_code, key_valid, key_held} !== expv())
                $display("FAIL hold_model cycle %0d: got %b expected %b", i,
                         {col_sel, key_code, key_valid, key_held}, expv());
            else passed++;
        end
        total++;
        if (pulses !== 0 || held_lost !== 0)
            $display("FAIL hold_steady: got %0d pulses %0d held-low cycles expected 0 0",
                     pulses, held_lost);
        else passed++;
    endtask

    task automatic test_release_repress();
        int fall   = 0;
        int pulses = 0;
        int code   = -1;
        keys[6] = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            if (key_held === 1'b0 && fall == 0) fall = i;
            total++;
            if ({col_sel, key_code, key_valid, key_held} !== expv())
                $display("FAIL release_model cycle %0d: got %b expected %b", i,
                         {col_sel, key_code, key_valid, key_held}, expv());
            else passed++;
        end
        total++;
        if (fall == 0 || fall <= 2 * SCAN)
            $display("FAIL release_latency: got %0d cycles expected %0d..%0d", fall,
                     2 * SCAN + 1, LAT);
        else passed++;
        total++;
        if (key_code !== 4'd6) $display("FAIL release_code_kept: got %0d expected 6", key_code);
        else passed++;
        keys[12] = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                pulses++;
                code = int'(key_code);
            end
            total++;
            if ({col_sel, key_code, key_valid, key_held} !== expv())
                $display("FAIL repress_model cycle %0d: got %b expected %b", i,
                         {col_sel, key_code, key_valid, key_held}, expv());
            else passed++;
        end
        total++;
        if (pulses !== 1 || code !== 12)
            $display("FAIL repress_code: got %0d pulses code %0d expected 1 pulse code 12",
                     pulses, code);
        else passed++;
        keys[12] = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            total++;
            if ({col_sel, key_code, key_valid, key_held} !== expv())
                $display("FAIL repress_release_model cycle %0d: got %b expected %b", i,
                         {col_sel, key_code, key_valid, key_held}, expv());
            else passed++;
        end
        total++;
        if (key_held !== 1'b0) $display("FAIL repress_released: got %b expected 0", key_held);
        else passed++;
    endtask

    task automatic test_bounce();
        int pulses    = 0;
        int held_seen = 0;
        int pre = $urandom_range(0, SCAN - 1);
        for (int i = 0; i < pre; i++) @(negedge clk);
        for (int s = 0; s < 12; s++) begin
            keys[1] = (s % 2 == 0);
            for (int i = 0; i < SCAN; i++) begin
                @(negedge clk);
                if (key_valid === 1'b1) pulses++;
                if (key_held === 1'b1) held_seen++;
                total++;
                if ({col_sel, key_code, key_valid, key_held} !== expv())
                    $display("FAIL bounce_model scan %0d: got %b expected %b", s,
                             {col_sel, key_code, key_valid, key_held}, expv());
                else passed++;
            end
        end
        keys = 16'h0;
        repeat (2 * SCAN) @(negedge clk);
        total++;
        if (pulses !== 0 || held_seen !== 0)
            $display("FAIL bounce_rejected: got %0d pulses %0d held cycles expected 0 0",
                     pulses, held_seen);
        else passed++;
    endtask

    task automatic test_ghost();
        logic [15:0] pats [2];
        pats[0] = 16'h0802;
        pats[1] = 16'h0022;
        for (int p = 0; p < 2; p++) begin
            int pulses = 0;
            keys = pats[p];
            for (int i = 1; i <= 8 * SCAN; i++) begin
                @(negedge clk);
                if (key_valid === 1'b1) pulses++;
                total++;
                if ({col_sel, key_code, key_valid, key_held} !== expv())
                    $display("FAIL ghost_model pattern %0d cycle %0d: got %b expected %b", p, i,
                             {col_sel, key_code, key_valid, key_held}, expv());
                else passed++;
            end
            keys = 16'h0;
            for (int i = 1; i <= 2 * SCAN; i++) begin
                @(negedge clk);
                if (key_valid === 1'b1) pulses++;
            end
            total++;
            if (pulses !== 0)
                $display("FAIL ghost_rejected pattern %0d: got %0d pulses expected 0", p, pulses);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_debounce();
        int waited = 0;
        int seen   = 0;
        int code   = -1;
        keys[10] = 1'b1;
        while (!(m.phase == 1 && m.cnt == 2) && waited < 4 * SCAN) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!(m.phase == 1 && m.cnt == 2))
            $display("FAIL midreset_reach_debounce: got %0d cycles expected under %0d",
                     waited, 4 * SCAN);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({col_sel, key_code, key_valid, key_held} !== 8'h00)
            $display("FAIL midreset_outputs: got %b expected %b",
                     {col_sel, key_code, key_valid, key_held}, 8'h00);
        else passed++;
        rst = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1 && seen == 0) begin
                seen = i;
                code = int'(key_code);
            end
            total++;
            if ({col_sel, key_code, key_valid, key_held} !== expv())
                $display("FAIL midreset_model cycle %0d: got %b expected %b", i,
                         {col_sel, key_code, key_valid, key_held}, expv());
            else passed++;
        end
        total++;
        if (seen !== 3 * SCAN || code !== 10)
            $display("FAIL midreset_accept: got cycle %0d code %0d expected cycle %0d code 10",
                     seen, code, 3 * SCAN);
        else passed++;
        keys = 16'h0;
        repeat (LAT) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_idle_scan();
        test_press();
        test_release_repress();
        test_bounce();
        test_ghost();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
